// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches four bytes from a byte-wide MMU port and presents big-endian 32-bit words to decode
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mmuAddr,
    output logic        mmuRequest,
    input  logic [7:0]  mmuData,
    input  logic        mmuBusy,
    output logic [31:0] instrOut,
    output logic [31:0] pcOut,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectPc
);
    typedef enum logic [1:0] {S_GAP, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [1:0]  r_byte_idx, w_byte_idx;
    logic [31:0] r_shift, w_shift;
    logic        r_redir_pending, w_redir_pending;
    logic [31:0] r_redir_target, w_redir_target;
    logic [31:0] r_mmu_addr, w_mmu_addr;
    logic        r_mmu_req, w_mmu_req;
    logic [31:0] r_instr, w_instr;
    logic [31:0] r_pc_out, w_pc_out;
    logic        r_valid, w_valid;
    logic [31:0] w_target;

    assign mmuAddr    = r_mmu_addr;
    assign mmuRequest = r_mmu_req;
    assign instrOut   = r_instr;
    assign pcOut      = r_pc_out;
    assign instrValid = r_valid;

    // A redirect seen during the completing cycle overrides any target latched earlier
    assign w_target = redirect ? (redirectPc & 32'hFFFF_FFFC) : r_redir_target;

    // Next-state and next-output computation; an in-flight MMU transaction always runs to completion
    always_comb begin
        w_state         = r_state;
        w_pc            = r_pc;
        w_byte_idx      = r_byte_idx;
        w_shift         = r_shift;
        w_redir_pending = r_redir_pending;
        w_redir_target  = r_redir_target;
        w_mmu_addr      = r_mmu_addr;
        w_mmu_req       = r_mmu_req;
        w_instr         = r_instr;
        w_pc_out        = r_pc_out;
        w_valid         = r_valid;
        unique case (r_state)
            S_GAP: begin
                if (redirect) begin
                    w_pc       = w_target;
                    w_byte_idx = 2'd0;
                end else begin
                    w_state    = S_REQ;
                    w_mmu_req  = 1'b1;
                    w_mmu_addr = r_pc + {30'd0, r_byte_idx};
                end
            end
            S_REQ: begin
                if (redirect) begin
                    w_redir_pending = 1'b1;
                    w_redir_target  = w_target;
                end
                if (mmuBusy) w_state = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    w_redir_pending = 1'b1;
                    w_redir_target  = w_target;
                end
                if (!mmuBusy) begin
                    w_mmu_req = 1'b0;
                    w_state   = S_GAP;
                    if (redirect || r_redir_pending) begin
                        w_pc            = w_target;
                        w_byte_idx      = 2'd0;
                        w_redir_pending = 1'b0;
                        w_redir_target  = w_target;
                    end else if (r_byte_idx == 2'd3) begin
                        w_state    = S_HOLD;
                        w_valid    = 1'b1;
                        w_instr    = {r_shift[31:8], mmuData};
                        w_pc_out   = r_pc;
                        w_byte_idx = 2'd0;
                    end else begin
                        w_shift[{~r_byte_idx, 3'b000} +: 8] = mmuData;
                        w_byte_idx = r_byte_idx + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc       = w_target;
                    w_byte_idx = 2'd0;
                    w_valid    = 1'b0;
                    w_state    = S_GAP;
                end else if (instrReady) begin
                    w_pc    = r_pc + 32'd4;
                    w_valid = 1'b0;
                    w_state = S_GAP;
                end
            end
            default: w_state = S_GAP;
        endcase
    end

    // State and registered outputs; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_GAP;
            r_pc            <= RESET_PC;
            r_byte_idx      <= 2'd0;
            r_shift         <= 32'd0;
            r_redir_pending <= 1'b0;
            r_redir_target  <= RESET_PC;
            r_mmu_addr      <= RESET_PC;
            r_mmu_req       <= 1'b0;
            r_instr         <= 32'd0;
            r_pc_out        <= RESET_PC;
            r_valid         <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_pc            <= w_pc;
            r_byte_idx      <= w_byte_idx;
            r_shift         <= w_shift;
            r_redir_pending <= w_redir_pending;
            r_redir_target  <= w_redir_target;
            r_mmu_addr      <= w_mmu_addr;
            r_mmu_req       <= w_mmu_req;
            r_instr         <= w_instr;
            r_pc_out        <= w_pc_out;
            r_valid         <= w_valid;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with an MMU responder and a word-level fetch model
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mmuAddr;
    logic        mmuRequest;
    logic [7:0]  mmuData = 8'h00;
    logic        mmuBusy = 1'b0;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        instrValid;
    logic        instrReady = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'd0;

    int tests = 0;
    int fails = 0;

    int busy_len = 1;
    int dly_cfg = 0;
    int busy_cnt = 0;
    int dly_cnt = 0;
    logic served = 1'b0;

    logic [31:0] exp_pc = 32'd0;
    logic [31:0] last_addr = 32'hFFFF_FFFF;
    logic [31:0] tgt = 32'd0;
    logic        rflag = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'd0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .mmuAddr(mmuAddr), .mmuRequest(mmuRequest),
        .mmuData(mmuData), .mmuBusy(mmuBusy), .instrOut(instrOut), .pcOut(pcOut),
        .instrValid(instrValid), .instrReady(instrReady), .redirect(redirect),
        .redirectPc(redirectPc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [31:0] a);
        case (a)
            32'd0: mem = 8'h3C;
            32'd1: mem = 8'h08;
            32'd2: mem = 8'h12;
            32'd3: mem = 8'h34;
            default: mem = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word(input logic [31:0] p);
        word = {mem(p), mem(p + 32'd1), mem(p + 32'd2), mem(p + 32'd3)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!instrValid && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, instrValid}, 32'd1);
    endtask

    task automatic wait_req_rise(input string name);
        int k = 0;
        while (mmuRequest && k < 300) begin
            @(negedge clk);
            k++;
        end
        while (!mmuRequest && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, mmuRequest}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirectPc = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    // MMU responder: optional delay before busy rises, busy_len cycles busy, data returned as busy falls
    always @(negedge clk) begin
        if (reset) begin
            mmuBusy = 1'b0;
            served = 1'b0;
            dly_cnt = 0;
        end else if (mmuBusy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                mmuBusy = 1'b0;
                mmuData = mem(mmuAddr);
            end
        end else if (mmuRequest && !served) begin
            if (dly_cnt < dly_cfg) dly_cnt++;
            else begin
                mmuBusy = 1'b1;
                busy_cnt = busy_len;
                served = 1'b1;
                dly_cnt = 0;
            end
        end else if (!mmuRequest) served = 1'b0;
    end

    // Word-level model: the next delivered PC advances by 4 per accept, or jumps to the last redirect
    always @(posedge clk) begin
        if (reset) begin
            exp_pc = 32'd0;
            last_addr = 32'hFFFF_FFFF;
            rflag = 1'b0;
        end else if (redirect) begin
            tgt = redirectPc & 32'hFFFF_FFFC;
            rflag = 1'b1;
            exp_pc = tgt;
        end else if (instrValid && instrReady) exp_pc = exp_pc + 32'd4;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (instrValid) begin
                chk("pc_out", pcOut, exp_pc);
                chk("instr_out", instrOut, word(exp_pc));
                chk("req_in_hold", {31'd0, mmuRequest}, 32'd0);
            end
            if (mmuRequest && !prev_req) begin
                last_addr = rflag ? tgt : last_addr + 32'd1;
                rflag = 1'b0;
                chk("req_addr", mmuAddr, last_addr);
            end
            if (mmuRequest && prev_req) chk("addr_stable", mmuAddr, prev_addr);
            prev_req = mmuRequest;
            prev_addr = mmuAddr;
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, mmuRequest}, 32'd0);
        chk("rst_valid", {31'd0, instrValid}, 32'd0);
        chk("rst_instr", instrOut, 32'd0);
        chk("rst_pc_out", pcOut, 32'd0);
        chk("rst_addr", mmuAddr, 32'd0);
        reset = 1'b0;
        n = 0;
        while (!instrValid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_latency", n, 12);
        @(negedge clk);
        chk("first_instr", instrOut, 32'h3C08_1234);
        chk("first_pc", pcOut, 32'd0);
        wait_req_rise("rise_after_accept");
        chk("next_addr", mmuAddr, 32'd4);
        instrReady = 1'b0;
        wait_valid("stall_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, instrValid}, 32'd1);
            chk("stall_pc", pcOut, 32'd4);
            chk("stall_req", {31'd0, mmuRequest}, 32'd0);
        end
        instrReady = 1'b1;
        wait_req_rise("rise_after_stall");
        chk("addr_after_stall", mmuAddr, 32'd8);
        busy_len = 5;
        pulse_redirect(32'd0);
        n = 0;
        while (!(mmuRequest && mmuBusy && mmuAddr == 32'd2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_addr2", mmuAddr, 32'd2);
        pulse_redirect(32'h105);
        wait_req_rise("rise_after_redir");
        chk("redir_addr", mmuAddr, 32'h104);
        wait_valid("redir_word");
        chk("redir_pc", pcOut, 32'h104);
        busy_len = 2;
        dly_cfg = 3;
        pulse_redirect(32'hFFFF_FFFC);
        chk("hold_redir_drop", {31'd0, instrValid}, 32'd0);
        instrReady = 1'b0;
        wait_valid("wrap_word");
        chk("wrap_pc", pcOut, 32'hFFFF_FFFC);
        instrReady = 1'b1;
        wait_req_rise("rise_after_wrap");
        chk("wrap_addr", mmuAddr, 32'd0);
        dly_cfg = 0;
        n = 0;
        while (!(mmuRequest && mmuBusy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mmuRequest}, 32'd0);
        chk("async_rst_addr", mmuAddr, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
